// File: rtl/out_port_buf.sv
// out_port_buf: per-output-port flit FIFO fed by a one-hot grant from rr_arb_5, with ready/send drain.
// Optional saturating departed-flit counter pkt_cnt when OUTBUF_STATS_EN is defined.
module out_port_buf #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [4:0]          gnt,
  input  logic [5*DATA_W-1:0] in_data,
  output logic                outbuf_full,
  output logic                out_send,
  output logic [DATA_W-1:0]   out_data,
  input  logic                out_ready,
  output logic                err
`ifdef OUTBUF_STATS_EN
  ,
  output logic [15:0]         pkt_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] HIGH = (AW+1)'(DEPTH-1);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [DATA_W-1:0] wdata;
  logic wr, one_hot, pop, acc;
  assign wr = |gnt;
  assign one_hot = wr & ~|(gnt & (gnt - 5'd1));
  assign pop = out_send & out_ready;
  assign acc = one_hot & ((count != FULL) | pop);
  assign out_send = count != '0;
  assign out_data = mem[rd_ptr];
  // anticipates the write committing at the same edge the arbiter samples this
  assign outbuf_full = (count == FULL) | ((count == HIGH) & wr & ~pop);
  always_comb begin
    wdata = '0;
    for (int i = 0; i < 5; i++) wdata = wdata | (in_data[i*DATA_W +: DATA_W] & {DATA_W{gnt[i]}});
  end
  always_ff @(posedge clk) if (acc) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      wr_ptr <= acc ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + {{AW{1'b0}}, acc} - {{AW{1'b0}}, pop};
      err    <= err | (wr & ~acc);
    end
`ifdef OUTBUF_STATS_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) pkt_cnt <= '0;
    else if (pop & ~&pkt_cnt) pkt_cnt <= pkt_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_out_port_buf.sv
// tb_out_port_buf: queue-based reference model checked every negedge, plus directed literal checks and random traffic.
module tb_out_port_buf;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 2;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [4:0] gnt = '0;
  logic [5*DATA_W-1:0] in_data = '0;
  logic out_ready = 1'b0;
  logic outbuf_full, out_send, err;
  logic [DATA_W-1:0] out_data;
`ifdef OUTBUF_STATS_EN
  logic [15:0] pkt_cnt;
`endif
  int passed = 0;
  int total = 0;
  logic [DATA_W-1:0] q[$];
  logic m_err = 1'b0;
  int m_pkt = 0;
  bit m_pop, m_ok;
  logic [DATA_W-1:0] m_flit;

  always #5 clk = ~clk;

  out_port_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .gnt(gnt),
    .in_data(in_data),
    .outbuf_full(outbuf_full),
    .out_send(out_send),
    .out_data(out_data),
    .out_ready(out_ready),
    .err(err)
`ifdef OUTBUF_STATS_EN
    ,
    .pkt_cnt(pkt_cnt)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Model holds the FIFO as a queue; it is compared, then advanced with the inputs the next edge will see.
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      m_err = 1'b0;
      m_pkt = 0;
    end
    chk("out_send", out_send, q.size() != 0);
    if (q.size() != 0) chk("out_data", out_data, q[0]);
    chk("err", err, m_err);
    chk("outbuf_full", outbuf_full,
        q.size() == DEPTH || (q.size() == DEPTH-1 && gnt != 0 && !(q.size() != 0 && out_ready)));
`ifdef OUTBUF_STATS_EN
    chk("pkt_cnt", pkt_cnt, 64'(m_pkt));
`endif
    if (reset_n) begin
      m_pop = q.size() != 0 && out_ready;
      m_ok = $countones(gnt) == 1 && (q.size() < DEPTH || m_pop);
      m_flit = '0;
      for (int i = 0; i < 5; i++) if (gnt[i]) m_flit = in_data[i*DATA_W +: DATA_W];
      if (m_pop) begin
        void'(q.pop_front());
        if (m_pkt < 65535) m_pkt++;
      end
      if (m_ok) q.push_back(m_flit);
      else if (gnt != 0) m_err = 1'b1;
    end
  end

  task automatic drive(input logic [4:0] g, input logic r);
    gnt = g;
    out_ready = r;
    for (int i = 0; i < 10; i++) in_data[i*32 +: 32] = $urandom;
    #1;
  endtask

  task automatic slot(input int i, input logic [63:0] v);
    in_data[i*DATA_W +: DATA_W] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] g;
    logic r;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_send", out_send, 0);
    chk("rst_full", outbuf_full, 0);
    chk("rst_err", err, 0);
    reset_n = 1'b1;
    drive(5'b00100, 1); slot(2, 64'hE0E0); tick();
    drive(0, 1); chk("single_send", out_send, 1); chk("single_data", out_data, 64'hE0E0); tick();
    drive(0, 1); chk("single_empty", out_send, 0); tick();
    drive(5'b00001, 0); slot(0, 64'hA0); chk("bp_full0", outbuf_full, 0); tick();
    drive(5'b00010, 0); slot(1, 64'hB1); chk("bp_full1", outbuf_full, 1); chk("bp_head", out_data, 64'hA0); tick();
    drive(0, 0); chk("bp_hold_full", outbuf_full, 1); chk("bp_err", err, 0); tick();
    drive(0, 1); chk("bp_pop_n", out_data, 64'hA0); chk("bp_full2", outbuf_full, 1); tick();
    drive(0, 1); chk("bp_pop_s", out_data, 64'hB1); chk("bp_full_fall", outbuf_full, 0); tick();
    drive(0, 1); chk("bp_empty", out_send, 0);
`ifdef OUTBUF_STATS_EN
    chk("pkt_cnt3", pkt_cnt, 3);
`endif
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(5'b00001 << k, 1);
      slot(k, 64'h5000 + 64'(k));
      if (k > 0) begin
        chk("stream_data", out_data, 64'h5000 + 64'(k - 1));
        chk("stream_full", outbuf_full, 0);
      end
      tick();
    end
    drive(0, 1); chk("stream_last", out_data, 64'h5004); tick();
    drive(0, 1); chk("stream_err", err, 0); tick();
    drive(5'b00011, 1); tick();
    drive(0, 1); chk("mh_err", err, 1); chk("mh_send", out_send, 0); tick();
    drive(5'b00001, 0); slot(0, 64'hC0); tick();
    drive(5'b00010, 0); slot(1, 64'hC1); tick();
    drive(5'b00100, 0); slot(2, 64'hC2); chk("ovf_full", outbuf_full, 1); tick();
    drive(0, 0); chk("ovf_err", err, 1); chk("ovf_head", out_data, 64'hC0); chk("ovf_send", out_send, 1); tick();
    drive(0, 1); tick();
    drive(0, 1); chk("ovf_second", out_data, 64'hC1); tick();
    drive(0, 1); chk("ovf_drained", out_send, 0); tick();
    drive(5'b00001, 0); tick();
    drive(5'b00010, 0); tick();
    drive(0, 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_send", out_send, 0);
    chk("mid_rst_full", outbuf_full, 0);
    chk("mid_rst_err", err, 0);
    tick();
    reset_n = 1'b1;
    drive(0, 1); chk("post_rst_send", out_send, 0); tick();
    drive(0, 1); chk("post_rst_send2", out_send, 0); tick();
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 3) != 0;
      g = 5'b00001 << $urandom_range(0, 9);
      if (!(q.size() < DEPTH || r)) g = '0;
      drive(g, r);
      tick();
    end
    drive(0, 1); chk("rand_err", err, 0); tick();
    for (int n = 0; n < 500; n++) begin
      drive(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      tick();
    end
    drive(0, 1); tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
